// File: rtl/gpu_pkg.sv
// Shared GPU definitions: dispatcher state encoding, the default block size
// shared with core, and block-arithmetic helpers.
package gpu_pkg;

    localparam int DEFAULT_THREADS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dispatch_state_e;

    // Ceiling division; the 9-bit sum keeps thread counts near 255 from wrapping.
    function automatic logic [7:0] blocks_for(input logic [7:0] threads, input int tpb);
        logic [8:0] sum;
        sum = {1'b0, threads} + 9'(tpb - 1);
        return 8'(sum / 9'(tpb));
    endfunction

    function automatic logic [7:0] block_threads(input logic [7:0] threads,
                                                 input logic [7:0] id,
                                                 input int         tpb);
        logic [15:0] rem;
        rem = 16'(threads) - 16'(id) * 16'(tpb);
        return (rem > 16'(tpb)) ? 8'(tpb) : rem[7:0];
    endfunction

endpackage

// File: rtl/dispatch.sv
// Kernel block dispatcher: splits a launch into fixed-size blocks, hands them
// to free cores in index order, and raises done once every block completes.
module dispatch
    import gpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = DEFAULT_THREADS_PER_BLOCK
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             thread_count,
    input  logic [NUM_CORES-1:0]   core_done,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [NUM_CORES-1:0]   core_reset,
    output logic [NUM_CORES*8-1:0] core_block_id,
    output logic [NUM_CORES*8-1:0] core_thread_count,
    output logic                   done
);

    dispatch_state_e      state_q, state_d;
    logic [7:0]           thread_count_q, thread_count_d;
    logic [7:0]           total_blocks_q, total_blocks_d;
    logic [7:0]           blocks_dispatched_q, blocks_dispatched_d;
    logic [7:0]           blocks_done_q, blocks_done_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [NUM_CORES-1:0] core_reset_q, core_reset_d;
    logic [7:0]           block_id_q  [NUM_CORES];
    logic [7:0]           block_id_d  [NUM_CORES];
    logic [7:0]           block_cnt_q [NUM_CORES];
    logic [7:0]           block_cnt_d [NUM_CORES];
    logic                 done_q, done_d;
    logic [7:0]           next_id;
    logic [7:0]           n_done;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
        state_d             = state_q;
        thread_count_d      = thread_count_q;
        total_blocks_d      = total_blocks_q;
        blocks_dispatched_d = blocks_dispatched_q;
        blocks_done_d       = blocks_done_q;
        core_start_d        = core_start_q;
        core_reset_d        = core_reset_q;
        block_id_d          = block_id_q;
        block_cnt_d         = block_cnt_q;
        done_d              = done_q;
        next_id             = blocks_dispatched_q;
        n_done              = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    thread_count_d = thread_count;
                    total_blocks_d = blocks_for(thread_count, THREADS_PER_BLOCK);
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (blocks_done_q == total_blocks_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    // A core completing this cycle is still out of reset, so it
                    // cannot be picked up again until the following edge.
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (core_start_q[i] && core_done[i]) begin
                            core_start_d[i] = 1'b0;
                            core_reset_d[i] = 1'b1;
                            n_done          = n_done + 8'd1;
                        end else if (core_reset_q[i] && (next_id < total_blocks_q)) begin
                            core_start_d[i] = 1'b1;
                            core_reset_d[i] = 1'b0;
                            block_id_d[i]   = next_id;
                            block_cnt_d[i]  = block_threads(thread_count_q, next_id,
                                                            THREADS_PER_BLOCK);
                            next_id         = next_id + 8'd1;
                        end
                    end
                    blocks_dispatched_d = next_id;
                    blocks_done_d       = blocks_done_q + n_done;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            thread_count_q      <= '0;
            total_blocks_q      <= '0;
            blocks_dispatched_q <= '0;
            blocks_done_q       <= '0;
            core_start_q        <= '0;
            core_reset_q        <= '1;
            done_q              <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                block_id_q[i]  <= '0;
                block_cnt_q[i] <= '0;
            end
        end else begin
            state_q             <= state_d;
            thread_count_q      <= thread_count_d;
            total_blocks_q      <= total_blocks_d;
            blocks_dispatched_q <= blocks_dispatched_d;
            blocks_done_q       <= blocks_done_d;
            core_start_q        <= core_start_d;
            core_reset_q        <= core_reset_d;
            done_q              <= done_d;
            block_id_q          <= block_id_d;
            block_cnt_q         <= block_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign core_block_id[g*8 +: 8]     = block_id_q[g];
        assign core_thread_count[g*8 +: 8] = block_cnt_q[g];
    end

    assign core_start = core_start_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: a per-cycle vector table plus a handshake
// sequence where a modelled pair of cores completes blocks on demand.
module tb_dispatch;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic [7:0]  tc;
        logic [1:0]  cd;
        logic [1:0]  e_cs;
        logic [1:0]  e_cr;
        logic [15:0] e_bid;
        logic [15:0] e_cnt;
        logic        e_dn;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count;
    logic [1:0]  core_done;
    logic [1:0]  core_start;
    logic [1:0]  core_reset;
    logic [15:0] core_block_id;
    logic [15:0] core_thread_count;
    logic        done;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    dispatch #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic [7:0] tc, input logic [1:0] cd,
                       input logic [1:0] cs, input logic [1:0] cr, input logic [15:0] bid,
                       input logic [15:0] cnt, input logic dn);
        vec_t v;
        v = '{rst, st, tc, cd, cs, cr, bid, cnt, dn};
        vecs.push_back(v);
    endtask

    initial begin
        int          cycles;
        int          n_blocks;
        logic [3:0]  seen;
        logic [7:0]  id;
        logic [7:0]  exp_cnt;

        reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0;

        //   rst st  tc     cd     cs     cr     bid       cnt       dn
        // 8 threads, two blocks, simultaneous completion, start ignored in DONE
        add(1, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd8,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd8,  2'b00, 2'b11, 2'b00, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd8,  2'b00, 2'b11, 2'b00, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd8,  2'b11, 2'b00, 2'b11, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd8,  2'b00, 2'b00, 2'b11, 16'h0100, 16'h0404, 1);
        add(0, 1, 8'd8,  2'b00, 2'b00, 2'b11, 16'h0100, 16'h0404, 1);
        // 10 threads, core1 finishes first and gets the 2-thread tail block
        add(1, 0, 8'd10, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd10, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd0,  2'b00, 2'b11, 2'b00, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd0,  2'b10, 2'b01, 2'b10, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd0,  2'b00, 2'b11, 2'b00, 16'h0200, 16'h0204, 0);
        add(0, 0, 8'd0,  2'b01, 2'b10, 2'b01, 16'h0200, 16'h0204, 0);
        add(0, 0, 8'd0,  2'b01, 2'b10, 2'b01, 16'h0200, 16'h0204, 0);
        add(0, 0, 8'd0,  2'b10, 2'b00, 2'b11, 16'h0200, 16'h0204, 0);
        add(0, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0200, 16'h0204, 1);
        // 16 threads, both cores complete together twice
        add(1, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd16, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd16, 2'b00, 2'b11, 2'b00, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd16, 2'b11, 2'b00, 2'b11, 16'h0100, 16'h0404, 0);
        add(0, 0, 8'd16, 2'b00, 2'b11, 2'b00, 16'h0302, 16'h0404, 0);
        add(0, 0, 8'd16, 2'b11, 2'b00, 2'b11, 16'h0302, 16'h0404, 0);
        add(0, 0, 8'd16, 2'b00, 2'b00, 2'b11, 16'h0302, 16'h0404, 1);
        // zero threads: straight to DONE at E1
        add(1, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 1);
        add(0, 1, 8'd4,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 1);
        // reset mid-run, relaunch with 4 threads, spurious core_done[1]
        add(1, 0, 8'd0,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd8,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd8,  2'b00, 2'b11, 2'b00, 16'h0100, 16'h0404, 0);
        add(1, 0, 8'd8,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 1, 8'd4,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'd4,  2'b00, 2'b01, 2'b10, 16'h0000, 16'h0004, 0);
        add(0, 0, 8'd4,  2'b10, 2'b01, 2'b10, 16'h0000, 16'h0004, 0);
        add(0, 0, 8'd4,  2'b00, 2'b01, 2'b10, 16'h0000, 16'h0004, 0);
        add(0, 0, 8'd4,  2'b01, 2'b00, 2'b11, 16'h0000, 16'h0004, 0);
        add(0, 0, 8'd4,  2'b00, 2'b00, 2'b11, 16'h0000, 16'h0004, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset        = vecs[i].rst;
            start        = vecs[i].st;
            thread_count = vecs[i].tc;
            core_done    = vecs[i].cd;
            tick();
            check($sformatf("row%0d start/reset", i), {core_start, core_reset},
                  {vecs[i].e_cs, vecs[i].e_cr});
            check($sformatf("row%0d block_id", i), core_block_id, vecs[i].e_bid);
            check($sformatf("row%0d thread_cnt", i), core_thread_count, vecs[i].e_cnt);
            check($sformatf("row%0d done", i), done, vecs[i].e_dn);
        end

        // 13 threads: cores acknowledge each block the cycle after it appears
        reset = 1'b1; start = 1'b0; core_done = '0;
        tick();
        reset = 1'b0; start = 1'b1; thread_count = 8'd13;
        tick();
        start = 1'b0;
        cycles = 0; n_blocks = 0; seen = '0;
        while (done !== 1'b1 && cycles < 50) begin
            core_done = '0;
            for (int c = 0; c < 2; c++) begin
                if (core_start[c] === 1'b1) begin
                    id = core_block_id[c*8 +: 8];
                    if (id < 8'd4 && !seen[id[1:0]]) begin
                        seen[id[1:0]] = 1'b1;
                        n_blocks++;
                        exp_cnt = (id == 8'd3) ? 8'd1 : 8'd4;
                        check($sformatf("hs block%0d count", id), core_thread_count[c*8 +: 8], exp_cnt);
                    end
                    core_done[c] = 1'b1;
                end
            end
            tick();
            cycles++;
        end
        core_done = '0;
        check("hs done within bound", done, 1'b1);
        check("hs block total", n_blocks, 4);
        check("hs ids seen", seen, 4'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
